// File: rtl/opp_pkg.sv
// Shared definitions for the opponent frame filter: payload field positions,
// reserved-bit mask, link state encoding and the held opponent state record.
package opp_pkg;

    localparam int X_HI    = 43;
    localparam int X_LO    = 33;
    localparam int Y_HI    = 31;
    localparam int Y_LO    = 21;
    localparam int DIR_HI  = 19;
    localparam int DIR_LO  = 11;
    localparam int GAME_HI = 7;
    localparam int GAME_LO = 5;
    localparam int RST_BIT = 3;

    // Bits 32, 20, [10:8], 4 and [2:0] carry no information and must be zero.
    localparam logic [43:0] RESERVED_MASK = 44'h001_0010_0717;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        LIVE  = 2'd1,
        STALE = 2'd2
    } link_state_e;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [8:0]  dir;
        logic [2:0]  game;
    } opp_state_t;

    // Pull the opponent fields out of a raw payload word.
    function automatic opp_state_t unpack_frame(input logic [43:0] d);
        opp_state_t s;
        s.x    = d[X_HI:X_LO];
        s.y    = d[Y_HI:Y_LO];
        s.dir  = d[DIR_HI:DIR_LO];
        s.game = d[GAME_HI:GAME_LO];
        return s;
    endfunction

endpackage

// File: rtl/opponent_frame_filter_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count qualifying events until the counter is full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/opponent_frame_filter.sv
// Opponent frame filter: validates received payloads, suppresses duplicates,
// holds the last good opponent state, qualifies the remote reset request and
// tracks link liveness with a timeout.
module opponent_frame_filter
    import opp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned RST_CONFIRM    = 3,
    parameter int unsigned MAX_X          = 1024,
    parameter int unsigned MAX_Y          = 768,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic             axiiv,
    input  logic [43:0]      axiid,
    output logic [10:0]      opp_x_out,
    output logic [10:0]      opp_y_out,
    output logic [8:0]       opp_dir_out,
    output logic [2:0]       opp_game_out,
    output logic             opp_rst_out,
    output logic             new_state_out,
    output logic             link_up_out,
    output logic [CNT_W-1:0] accepted_cnt_out,
    output logic [CNT_W-1:0] rejected_cnt_out
);

    localparam int unsigned TIM_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CONF_W = $clog2(RST_CONFIRM + 1);
    localparam logic [TIM_W-1:0]  TIM_LAST = TIM_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(RST_CONFIRM);

    link_state_e        state_q, state_d;
    logic [TIM_W-1:0]   timer_q, timer_d;
    logic [CONF_W-1:0]  confirm_q, confirm_d;
    logic               rst_q, rst_d;
    logic               new_state_q, new_state_d;
    logic [43:0]        last_q, last_d;
    opp_state_t         held_q, held_d;

    logic frame_ok;
    logic accept;
    logic reject;
    logic dup;

    // Payload validity: reserved bits clear, every field in range, not all-zero.
    always_comb begin
        frame_ok = ((axiid & RESERVED_MASK) == '0)
                && (32'(axiid[X_HI:X_LO])     < MAX_X)
                && (32'(axiid[Y_HI:Y_LO])     < MAX_Y)
                && (32'(axiid[DIR_HI:DIR_LO]) < 32'd360)
                && (axiid != '0);
    end

    assign accept = axiiv & frame_ok;
    assign reject = axiiv & ~frame_ok;
    assign dup    = accept && (axiid == last_q);

    // Next-state logic for the link FSM, timeout, reset qualification and held state.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        timer_d     = timer_q;
        confirm_d   = confirm_q;
        held_d      = held_q;
        last_d      = last_q;
        new_state_d = 1'b0;

        if (accept) begin
            // An accepted frame wins over a timeout expiring in the same cycle.
            state_d = LIVE;
            timer_d = '0;
            if (axiid[RST_BIT]) begin
                confirm_d = (confirm_q == CONF_MAX) ? confirm_q : confirm_q + CONF_W'(1);
            end else begin
                confirm_d = '0;
            end
            if (!dup) begin
                held_d      = unpack_frame(axiid);
                last_d      = axiid;
                new_state_d = 1'b1;
            end
        end else if (state_q == LIVE) begin
            if (timer_q == TIM_LAST) begin
                state_d = STALE;
            end else begin
                timer_d = timer_q + TIM_W'(1);
            end
        end

        // A stale link must never present a pending remote reset.
        if (state_d == STALE) begin
            confirm_d = '0;
        end
        rst_d = (confirm_d == CONF_MAX);
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= WAIT;
            timer_q     <= '0;
            confirm_q   <= '0;
            rst_q       <= 1'b0;
            new_state_q <= 1'b0;
            last_q      <= '0;
            held_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            confirm_q   <= confirm_d;
            rst_q       <= rst_d;
            new_state_q <= new_state_d;
            last_q      <= last_d;
            held_q      <= held_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_accepted_cnt (
        .clk_i   (clk_in),
        .rst_ni  (rst_in_n),
        .inc_i   (accept),
        .count_o (accepted_cnt_out)
    );

    sat_counter #(.WIDTH(CNT_W)) u_rejected_cnt (
        .clk_i   (clk_in),
        .rst_ni  (rst_in_n),
        .inc_i   (reject),
        .count_o (rejected_cnt_out)
    );

    assign opp_x_out     = held_q.x;
    assign opp_y_out     = held_q.y;
    assign opp_dir_out   = held_q.dir;
    assign opp_game_out  = held_q.game;
    assign opp_rst_out   = rst_q;
    assign new_state_out = new_state_q;
    assign link_up_out   = (state_q == LIVE);

endmodule
